alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port arbiter that time-shares a single ALU instance between two independent requesters, for example the execute stage and a multi-cycle address/branch helper. Each port issues operations through a valid/ready request channel. The arbiter grants at most one operation per cycle using round-robin priority and returns the registered result on that port's own valid/ready response channel. Each port has a one-entry response buffer, so backpressure on one port never blocks the other.

## Interface
Parameters:
- DATA_W, 32, operand/result width; fixed at 32 to match the ALU datapath.
- SEL_W, 4, ALU opcode width; fixed at 4.

Ports (x = 0, 1; one set per requester):
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid_x  in  1  port x has an operation.
- req_ready_x  out  1  port x operation accepted this cycle (combinational).
- req_sel_x  in  SEL_W  ALU opcode.
- req_a_x  in  DATA_W  operand A.
- req_b_x  in  DATA_W  operand B.
- resp_valid_x  out  1  port x result held.
- resp_ready_x  in  1  port x consumer takes result.
- resp_out_x  out  DATA_W  result.
- resp_zero_x  out  1  result equals zero.

## Operation
- Opcode set is the ALU's, unchanged: 0000 add, 0001 sub, 0010 xor, 0011 or, 0100 and, 0101 sll, 0110 srl, 0111 sra slot, 1000/1001 set-less-than. Any other code gives a result of 0 with zero = 1. The arbiter never decodes or alters sel.
- Port x is eligible when req_valid_x = 1 and its response slot can take a result: resp_valid_x = 0, or resp_ready_x = 1 in the same cycle.
- Arbitration:
  - Only one port eligible: that port is granted.
  - Both ports eligible: the port named by the priority pointer `prio` (1 bit) is granted.
  - Neither port eligible: no grant; the ALU inputs are don't-care.
- req_ready_x = grant_x. grant_0 and grant_1 are never both 1.
- `prio` update: after any grant, `prio` moves to the non-granted port. With no grant, `prio` holds. Under continuous two-port load this gives strict alternation.
- The mux drives the granted port's sel/A/B into the ALU. On the next edge, the ALU out and zeroflag are written into that port's response register and resp_valid_x is set.
- Response slot x:
  - Set on grant_x.
  - Cleared when resp_valid_x & resp_ready_x and there is no new grant_x in the same cycle.
  - When drain and grant happen in the same cycle, the slot is overwritten with the new result and resp_valid_x stays 1.
- resp_out_x and resp_zero_x are stable while resp_valid_x = 1 and resp_ready_x = 0.
- Results never cross ports: port 0 data appears only on resp_*_0.

## Timing
- Reset (rst = 1 at an edge):
  - resp_valid_x = 0, resp_out_x = 0, resp_zero_x = 0, prio = 0.
  - req_ready_x is forced to 0 while rst = 1.
- Latency: a request accepted in cycle N has its result valid in cycle N+1.
- Aggregate throughput: 1 operation per cycle. Per-port throughput: 1 per cycle when uncontended with resp_ready held high, 1 per 2 cycles under full contention.
- Reset asserted mid-operation: a pending response is discarded (resp_valid cleared) and any request presented in that cycle is not accepted.
- Requester rules: req_* must stay stable while req_valid_x = 1 and req_ready_x = 0. The arbiter does not require this for correctness, but verification checks it as an assumption.
- Combinational paths:
  - req_valid, resp_valid, resp_ready → req_ready is combinational.
  - There is no combinational path from req_* to resp_*.

## Structure
- Shared package `alu_pkg`:
  - Opcode localparams: ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU.
  - DATA_W and SEL_W.
- Sub-modules:
  - One instance of the existing ALU module as the shared datapath.
  - One small sub-module `rr_arb2`: 2-way round-robin grant logic that owns the `prio` register.
- Everything else (operand mux, two response registers) is inline.

## Test plan
- Single port: port 0 sends sel = 0000, A = 5, B = 7, with resp_ready_0 = 1 → req_ready_0 = 1 in the same cycle; next cycle resp_out_0 = 12, resp_zero_0 = 0, and port 1 stays idle.
- Contention after reset: both ports request every cycle; port 0 sends sub 9 − 9 and port 1 sends xor 0xF0F0 ^ 0x0FF0. Required response:
  - Grants go 0, 1, 0, 1.
  - resp_zero_0 = 1.
  - resp_out_1 = 0x0000FF00.
- Backpressure: hold resp_ready_1 = 0 with port 1's slot full and both ports requesting → port 1 gets no grant, port 0 is granted every cycle, and resp_out_1 stays constant. Releasing resp_ready_1 → port 1 is granted that same cycle.
- Same-cycle drain and refill: with resp_valid_0 = 1 and resp_ready_0 = 1, a new request or1 | 2 → resp_valid_0 stays 1 and resp_out_0 = 3 next cycle.
- Reset mid-flight: pulse rst in the cycle after a grant → resp_valid_x = 0, outputs = 0 and prio = 0 after that edge; the first contended grant after reset goes to port 0.
- Opcode passthrough: run every sel value 0000–1111 on port 1 with A = 1, B = 4 → results match the ALU; sel 1010–1111 give out = 0, zero = 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths and opcode encodings.
package alu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;

  localparam logic [SEL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [SEL_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [SEL_W-1:0] ALU_XOR  = 4'b0010;
  localparam logic [SEL_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [SEL_W-1:0] ALU_AND  = 4'b0100;
  localparam logic [SEL_W-1:0] ALU_SLL  = 4'b0101;
  localparam logic [SEL_W-1:0] ALU_SRL  = 4'b0110;
  localparam logic [SEL_W-1:0] ALU_SRA  = 4'b0111;
  localparam logic [SEL_W-1:0] ALU_SLT  = 4'b1000;
  localparam logic [SEL_W-1:0] ALU_SLTU = 4'b1001;

endpackage

// File: rtl/alu.sv
// Combinational ALU; unknown opcodes yield zero.
module alu
  import alu_pkg::*;
(
  input  logic [SEL_W-1:0]  sel_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] out_o,
  output logic              zero_o
);

  localparam int unsigned ShamtW = $clog2(DATA_W);

  logic [ShamtW-1:0] shamt;
  logic              lt_s;
  logic              lt_u;

  assign shamt = b_i[ShamtW-1:0];
  assign lt_s  = $signed(a_i) < $signed(b_i);
  assign lt_u  = a_i < b_i;

  always_comb begin
    out_o = '0;
    case (sel_i)
      ALU_ADD:  out_o = a_i + b_i;
      ALU_SUB:  out_o = a_i - b_i;
      ALU_XOR:  out_o = a_i ^ b_i;
      ALU_OR:   out_o = a_i | b_i;
      ALU_AND:  out_o = a_i & b_i;
      ALU_SLL:  out_o = a_i << shamt;
      ALU_SRL:  out_o = a_i >> shamt;
      ALU_SRA:  out_o = $unsigned($signed(a_i) >>> shamt);
      ALU_SLT:  out_o = {{(DATA_W-1){1'b0}}, lt_s};
      ALU_SLTU: out_o = {{(DATA_W-1){1'b0}}, lt_u};
      default:  out_o = '0;
    endcase
  end

  assign zero_o = (out_o == '0);

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; prio names the winner when both are eligible.
module rr_arb2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (!rst_i) begin
      gnt0_o = req0_i & (~req1_i | ~prio_q);
      gnt1_o = req1_i & (~req0_i | prio_q);
    end
    prio_d = prio_q;
    if (gnt0_o) begin
      prio_d = 1'b1;
    end else if (gnt1_o) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Time-shares one ALU between two requesters with per-port one-entry result slots.
module alu_arbiter #(
  parameter int unsigned DATA_W = alu_pkg::DATA_W,
  parameter int unsigned SEL_W  = alu_pkg::SEL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_0,
  output logic              req_ready_0,
  input  logic [SEL_W-1:0]  req_sel_0,
  input  logic [DATA_W-1:0] req_a_0,
  input  logic [DATA_W-1:0] req_b_0,
  output logic              resp_valid_0,
  input  logic              resp_ready_0,
  output logic [DATA_W-1:0] resp_out_0,
  output logic              resp_zero_0,
  input  logic              req_valid_1,
  output logic              req_ready_1,
  input  logic [SEL_W-1:0]  req_sel_1,
  input  logic [DATA_W-1:0] req_a_1,
  input  logic [DATA_W-1:0] req_b_1,
  output logic              resp_valid_1,
  input  logic              resp_ready_1,
  output logic [DATA_W-1:0] resp_out_1,
  output logic              resp_zero_1
);

  logic              elig_0, elig_1;
  logic              grant_0, grant_1;
  logic [SEL_W-1:0]  alu_sel;
  logic [DATA_W-1:0] alu_a, alu_b, alu_out;
  logic              alu_zero;

  logic              valid_0_q, valid_0_d, valid_1_q, valid_1_d;
  logic [DATA_W-1:0] out_0_q, out_0_d, out_1_q, out_1_d;
  logic              zero_0_q, zero_0_d, zero_1_q, zero_1_d;

  // A full slot can still accept when its consumer drains it this cycle.
  assign elig_0 = req_valid_0 & (~valid_0_q | resp_ready_0);
  assign elig_1 = req_valid_1 & (~valid_1_q | resp_ready_1);

  rr_arb2 u_rr_arb2 (
    .clk_i  (clk),
    .rst_i  (rst),
    .req0_i (elig_0),
    .req1_i (elig_1),
    .gnt0_o (grant_0),
    .gnt1_o (grant_1)
  );

  assign req_ready_0 = grant_0;
  assign req_ready_1 = grant_1;

  assign alu_sel = grant_1 ? req_sel_1 : req_sel_0;
  assign alu_a   = grant_1 ? req_a_1   : req_a_0;
  assign alu_b   = grant_1 ? req_b_1   : req_b_0;

  alu u_alu (
    .sel_i  (alu_sel),
    .a_i    (alu_a),
    .b_i    (alu_b),
    .out_o  (alu_out),
    .zero_o (alu_zero)
  );

  always_comb begin
    valid_0_d = valid_0_q;
    out_0_d   = out_0_q;
    zero_0_d  = zero_0_q;
    valid_1_d = valid_1_q;
    out_1_d   = out_1_q;
    zero_1_d  = zero_1_q;
    if (grant_0) begin
      valid_0_d = 1'b1;
      out_0_d   = alu_out;
      zero_0_d  = alu_zero;
    end else if (valid_0_q && resp_ready_0) begin
      valid_0_d = 1'b0;
    end
    if (grant_1) begin
      valid_1_d = 1'b1;
      out_1_d   = alu_out;
      zero_1_d  = alu_zero;
    end else if (valid_1_q && resp_ready_1) begin
      valid_1_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_0_q <= 1'b0;
      out_0_q   <= '0;
      zero_0_q  <= 1'b0;
      valid_1_q <= 1'b0;
      out_1_q   <= '0;
      zero_1_q  <= 1'b0;
    end else begin
      valid_0_q <= valid_0_d;
      out_0_q   <= out_0_d;
      zero_0_q  <= zero_0_d;
      valid_1_q <= valid_1_d;
      out_1_q   <= out_1_d;
      zero_1_q  <= zero_1_d;
    end
  end

  assign resp_valid_0 = valid_0_q;
  assign resp_out_0   = out_0_q;
  assign resp_zero_0  = zero_0_q;
  assign resp_valid_1 = valid_1_q;
  assign resp_out_1   = out_1_q;
  assign resp_zero_1  = zero_1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: grants, backpressure, reset and opcode sweep.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_0, req_ready_0, resp_valid_0, resp_ready_0, resp_zero_0;
  logic        req_valid_1, req_ready_1, resp_valid_1, resp_ready_1, resp_zero_1;
  logic [3:0]  req_sel_0, req_sel_1;
  logic [31:0] req_a_0, req_b_0, req_a_1, req_b_1, resp_out_0, resp_out_1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_out [16];
  logic        exp_zero [16];

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_0  (req_valid_0),
    .req_ready_0  (req_ready_0),
    .req_sel_0    (req_sel_0),
    .req_a_0      (req_a_0),
    .req_b_0      (req_b_0),
    .resp_valid_0 (resp_valid_0),
    .resp_ready_0 (resp_ready_0),
    .resp_out_0   (resp_out_0),
    .resp_zero_0  (resp_zero_0),
    .req_valid_1  (req_valid_1),
    .req_ready_1  (req_ready_1),
    .req_sel_1    (req_sel_1),
    .req_a_1      (req_a_1),
    .req_b_1      (req_b_1),
    .resp_valid_1 (resp_valid_1),
    .resp_ready_1 (resp_ready_1),
    .resp_out_1   (resp_out_1),
    .resp_zero_1  (resp_zero_1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_out  = '{32'd5, 32'hFFFF_FFFD, 32'd5, 32'd5, 32'd0, 32'd16, 32'd0, 32'd0,
                 32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    exp_zero = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
                 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    rst = 1'b1;
    req_valid_0 = 1'b1; req_sel_0 = 4'd0; req_a_0 = 32'd5; req_b_0 = 32'd7;
    req_valid_1 = 1'b0; req_sel_1 = 4'd0; req_a_1 = 32'd0; req_b_1 = 32'd0;
    resp_ready_0 = 1'b1; resp_ready_1 = 1'b1;
    cycle();
    check("rst_ready0", req_ready_0, 1'b0);
    check("rst_valid0", resp_valid_0, 1'b0);
    check("rst_valid1", resp_valid_1, 1'b0);
    check("rst_out0", resp_out_0, 32'd0);
    check("rst_out1", resp_out_1, 32'd0);
    check("rst_zero0", resp_zero_0, 1'b0);
    check("rst_zero1", resp_zero_1, 1'b0);

    // Single port: add 5 + 7 on port 0.
    rst = 1'b0;
    #1;
    check("single_ready0", req_ready_0, 1'b1);
    check("single_ready1", req_ready_1, 1'b0);
    cycle();
    check("single_valid0", resp_valid_0, 1'b1);
    check("single_out0", resp_out_0, 32'd12);
    check("single_zero0", resp_zero_0, 1'b0);
    check("single_valid1", resp_valid_1, 1'b0);

    // Reset right after a grant (prio now points at port 1).
    rst = 1'b1;
    #1;
    check("midrst_ready0", req_ready_0, 1'b0);
    cycle();
    check("midrst_valid0", resp_valid_0, 1'b0);
    check("midrst_out0", resp_out_0, 32'd0);
    check("midrst_zero0", resp_zero_0, 1'b0);
    rst = 1'b0;

    // Contention: sub 9-9 on port 0, xor on port 1.
    req_valid_0 = 1'b1; req_sel_0 = 4'd1; req_a_0 = 32'd9; req_b_0 = 32'd9;
    req_valid_1 = 1'b1; req_sel_1 = 4'd2; req_a_1 = 32'h0000_F0F0; req_b_1 = 32'h0000_0FF0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("cont%0d_ready0", i), req_ready_0, (i % 2) == 0);
      check($sformatf("cont%0d_ready1", i), req_ready_1, (i % 2) == 1);
      cycle();
      if (i == 0) begin
        check("cont_zero0", resp_zero_0, 1'b1);
        check("cont_out0", resp_out_0, 32'd0);
      end
      if (i == 1) begin
        check("cont_out1", resp_out_1, 32'h0000_FF00);
        check("cont_zero1", resp_zero_1, 1'b0);
      end
    end

    // Backpressure on port 1 with its slot full.
    resp_ready_1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp%0d_ready0", i), req_ready_0, 1'b1);
      check($sformatf("bp%0d_ready1", i), req_ready_1, 1'b0);
      cycle();
      check($sformatf("bp%0d_valid1", i), resp_valid_1, 1'b1);
      check($sformatf("bp%0d_out1", i), resp_out_1, 32'h0000_FF00);
    end
    resp_ready_1 = 1'b1;
    #1;
    check("release_ready1", req_ready_1, 1'b1);
    check("release_ready0", req_ready_0, 1'b0);
    cycle();
    check("release_valid1", resp_valid_1, 1'b1);
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    cycle();
    check("drain_valid0", resp_valid_0, 1'b0);
    check("drain_valid1", resp_valid_1, 1'b0);

    // Same-cycle drain and refill on port 0.
    req_valid_0 = 1'b1; req_sel_0 = 4'd0; req_a_0 = 32'd5; req_b_0 = 32'd7;
    cycle();
    check("refill_pre_out0", resp_out_0, 32'd12);
    req_sel_0 = 4'd3; req_a_0 = 32'd1; req_b_0 = 32'd2;
    #1;
    check("refill_ready0", req_ready_0, 1'b1);
    cycle();
    check("refill_valid0", resp_valid_0, 1'b1);
    check("refill_out0", resp_out_0, 32'd3);
    req_valid_0 = 1'b0;
    cycle();
    check("refill_drained0", resp_valid_0, 1'b0);

    // Opcode sweep on port 1, back to back.
    req_valid_1 = 1'b1; req_a_1 = 32'd1; req_b_1 = 32'd4;
    for (int s = 0; s < 16; s++) begin
      req_sel_1 = 4'(s);
      #1;
      check($sformatf("op%0d_ready1", s), req_ready_1, 1'b1);
      cycle();
      check($sformatf("op%0d_valid1", s), resp_valid_1, 1'b1);
      check($sformatf("op%0d_out1", s), resp_out_1, exp_out[s]);
      check($sformatf("op%0d_zero1", s), resp_zero_1, exp_zero[s]);
      check($sformatf("op%0d_valid0", s), resp_valid_0, 1'b0);
    end
    req_valid_1 = 1'b0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
